ysyx_23060111_mem_arb: RTL

Two-requester arbiter and sequencer for the core's single data/instruction memory port. It shares the port between the IFU (instruction fetch, read-only) and the LSU (EXU load/store). It latches one request at a time, drives the memory handshake and routes the response back to the owner. A grant counter keeps the IFU from starving, and a watchdog times out hung transactions. It sits between the IFU/EXU and the memory model in the multi-cycle core top.

---
 rtl/ysyx_23060111_mem_arb.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060111_mem_arb.sv
// ysyx_23060111_mem_arb: shares the single memory port between the IFU and the LSU.
// One transaction is outstanding at a time. The owner's request is latched at grant time,
// it is issued to memory and the response is routed back with a registered one-cycle pulse.
// An LSU grant streak counter stops the IFU from starving. A watchdog aborts hung
// transactions with an error response.
module ysyx_23060111_mem_arb #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int LSU_BURST_MAX = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_gnt,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  output logic          ifu_err,
  input  logic          lsu_req,
  input  logic          lsu_we,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [3:0]    lsu_wmask,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  output logic          lsu_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_err,
  output logic          busy
);

  localparam int SW = $clog2(LSU_BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_lsu_q, owner_lsu_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          ifu_rvalid_q, lsu_rvalid_q;
  logic          ifu_err_q, lsu_err_q;
  logic [DW-1:0] ifu_rdata_q, lsu_rdata_q;

  logic          rsp_set;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;
  logic          gnt_ifu, gnt_lsu;
  logic          mem_req_c;
  logic          tmo_hit;

  // Next-state logic: arbitration in IDLE, memory handshake in ISSUE/WAIT, watchdog abort
  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    rsp_set     = 1'b0;
    rsp_err     = 1'b0;
    rsp_data    = '0;
    gnt_ifu     = 1'b0;
    gnt_lsu     = 1'b0;
    mem_req_c   = 1'b0;
    tmo_hit     = (tmo_q == TW'(TIMEOUT));

    case (state_q)
      ST_IDLE: begin
        if (ifu_req && (!lsu_req || streak_q == SW'(LSU_BURST_MAX))) begin
          gnt_ifu     = 1'b1;
          owner_lsu_d = 1'b0;
          we_d        = 1'b0;
          addr_d      = ifu_addr;
          wdata_d     = '0;
          wmask_d     = 4'hF;
          streak_d    = '0;
          state_d     = ST_ISSUE;
        end else if (lsu_req) begin
          gnt_lsu     = 1'b1;
          owner_lsu_d = 1'b1;
          we_d        = lsu_we;
          addr_d      = lsu_addr;
          wdata_d     = lsu_wdata;
          wmask_d     = lsu_wmask;
          if (streak_q != SW'(LSU_BURST_MAX)) begin
            streak_d = streak_q + SW'(1);
          end
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (tmo_hit) begin
          rsp_set = 1'b1;
          rsp_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_req_c = 1'b1;
          tmo_d     = tmo_q + TW'(1);
          if (mem_gnt) begin
            if (mem_rvalid) begin
              rsp_set  = 1'b1;
              rsp_err  = mem_err;
              rsp_data = (owner_lsu_q && we_q) ? '0 : mem_rdata;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (tmo_hit) begin
          rsp_set = 1'b1;
          rsp_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (mem_rvalid) begin
            rsp_set  = 1'b1;
            rsp_err  = mem_err;
            rsp_data = (owner_lsu_q && we_q) ? '0 : mem_rdata;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) begin
      tmo_d = '0;
    end
  end

  // State, latched request fields, streak and watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_lsu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  // Registered response: one-cycle rvalid to the owner, rdata holds until its next response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      lsu_err_q    <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      ifu_rvalid_q <= rsp_set && !owner_lsu_q;
      lsu_rvalid_q <= rsp_set && owner_lsu_q;
      ifu_err_q    <= rsp_set && !owner_lsu_q && rsp_err;
      lsu_err_q    <= rsp_set && owner_lsu_q && rsp_err;
      if (rsp_set && !owner_lsu_q) begin
        ifu_rdata_q <= rsp_data;
      end
      if (rsp_set && owner_lsu_q) begin
        lsu_rdata_q <= rsp_data;
      end
    end
  end

  // Grants are gated with reset so every output is low while reset is held
  assign ifu_gnt    = gnt_ifu && rst;
  assign lsu_gnt    = gnt_lsu && rst;
  assign ifu_rvalid = ifu_rvalid_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign ifu_err    = ifu_err_q;
  assign lsu_err    = lsu_err_q;
  assign mem_req    = mem_req_c;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
